// File: rtl/sp_ram_pkg.sv
// Shared constants and types for the byte-enable scratch RAM: read-during-write
// modes, clear-sequence state encoding and the lane-count helper.
package sp_ram_pkg;

    localparam int RW_READ_FIRST  = 0;
    localparam int RW_WRITE_FIRST = 1;
    localparam int RW_NO_CHANGE   = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } ram_state_e;

    function automatic int lane_count(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/sp_ram_rd_pipe.sv
// Read-data delay line: stage 0 captures data only when loaded, later stages
// shift every cycle. All data and valid bits reset asynchronously to zero.
module sp_ram_rd_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stage_load_i,
    input  logic [DATA_WIDTH-1:0] stage_data_i,
    input  logic                  stage_valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] data_q;
    logic [RD_LATENCY-1:0]                 valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            // Stage 0 holds its data when nothing is loaded; valid is always refreshed.
            if (stage_load_i) begin
                data_q[0] <= stage_data_i;
            end
            valid_q[0] <= stage_valid_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign data_o  = data_q[RD_LATENCY-1];
    assign valid_o = valid_q[RD_LATENCY-1];

endmodule

// File: rtl/sp_sync_ram_be.sv
// Single-port synchronous RAM with byte-lane write enables, configurable read
// latency, selectable read-during-write output and a post-reset clear sweep.
module sp_sync_ram_be
    import sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 16,
    parameter int BYTE_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RW_MODE        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cs,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic                             oe,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rvalid,
    output logic                             busy
);

    localparam int NUM_LANES = lane_count(DATA_WIDTH, BYTE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ram_state_e            state_q;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;

    logic                  req;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  stage_load_d;
    logic [DATA_WIDTH-1:0] stage_data_d;
    logic                  stage_valid_d;
    logic [DATA_WIDTH-1:0] pipe_data;
    logic                  pipe_valid;

    assign req      = cs && !busy_q;
    assign in_range = ({1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH));
    assign old_word = in_range ? mem[addr] : '0;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign merged_word[gi*BYTE_WIDTH +: BYTE_WIDTH] =
                be[gi] ? wdata[gi*BYTE_WIDTH +: BYTE_WIDTH]
                       : old_word[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    // The clear sweep owns the single write port while busy.
    assign mem_we    = busy_q || (req && we && in_range);
    assign mem_waddr = busy_q ? clr_cnt_q : addr;
    assign mem_wdata = busy_q ? '0 : merged_word;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
            busy_q    <= (CLEAR_ON_RESET != 0);
            clr_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        clr_cnt_q <= '0;
                    end
                end
                ST_IDLE: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stage_load_d  = 1'b0;
        stage_data_d  = old_word;
        stage_valid_d = req && !we;
        if (req && !we) begin
            stage_load_d = 1'b1;
        end else if (req && we) begin
            if (RW_MODE == RW_READ_FIRST) begin
                stage_load_d = 1'b1;
            end else if (RW_MODE == RW_WRITE_FIRST) begin
                stage_load_d = 1'b1;
                stage_data_d = in_range ? merged_word : '0;
            end
        end
    end

    sp_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .stage_load_i  (stage_load_d),
        .stage_data_i  (stage_data_d),
        .stage_valid_i (stage_valid_d),
        .data_o        (pipe_data),
        .valid_o       (pipe_valid)
    );

    assign rdata  = oe ? pipe_data : '0;
    assign rvalid = pipe_valid;
    assign busy   = busy_q;

endmodule

// File: doc/sp_sync_ram_be.md
Name: sp_sync_ram_be

Overview:
Parametrised single-port synchronous RAM with per-byte write enables and a configurable read latency. It has a selectable read-during-write behaviour and an optional hardware clear sequence after reset. Separate write and read data buses replace the earlier bidirectional data port. It is the standard on-chip scratch memory for the team's datapath blocks and is driven by a simple cs/we request interface.

Parameters:
ADDR_WIDTH, 4, address bus width.
DATA_WIDTH, 16, word width; must be a multiple of BYTE_WIDTH.
DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
BYTE_WIDTH, 8, bits per byte-enable lane.
RD_LATENCY, 1, clock edges from read request to rdata/rvalid; legal values 1..3.
RW_MODE, 0, rdata on a write cycle: 0 = read-first, 1 = write-first, 2 = no-change.
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents undefined.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
cs  input  1  chip select; a request is issued on any edge with cs=1 and busy=0.
we  input  1  1 = write, 0 = read (qualified by cs).
be  input  DATA_WIDTH/BYTE_WIDTH  byte-lane write enables.
addr  input  ADDR_WIDTH  word address.
wdata  input  DATA_WIDTH  write data.
oe  input  1  output enable; rdata = oe ? registered data : 0 (combinational gate).
rdata  output  DATA_WIDTH  read data.
rvalid  output  1  one-cycle pulse per completed read.
busy  output  1  clear sequence in progress; requests are ignored while high.

Behaviour:
- Reset assertion, asynchronous:
  - all read-pipeline data and valid registers go to 0, so rdata=0 and rvalid=0;
  - the clear counter goes to 0;
  - busy = CLEAR_ON_RESET.
- FSM states INIT and IDLE:
  - reset state is INIT if CLEAR_ON_RESET=1, otherwise IDLE;
  - INIT writes 0 to address clr_cnt on each edge and increments clr_cnt;
  - after writing DEPTH-1, INIT goes to IDLE; busy falls on that same edge;
  - INIT therefore lasts exactly DEPTH cycles after rst_n deasserts;
  - reset asserted during INIT restarts the sequence at address 0.
- Requests with cs=1 while busy=1 are dropped: no write, no rvalid, no queuing.
- Write (cs=1, we=1, busy=0):
  - on the edge, byte lane i of mem[addr] takes wdata lane i where be[i]=1; other lanes keep their value;
  - be all-zero leaves memory unchanged;
  - a write never raises rvalid.
- Read (cs=1, we=0, busy=0):
  - mem[addr] is sampled on the request edge;
  - rdata/rvalid appear after RD_LATENCY edges; with RD_LATENCY=1, data is visible in the cycle after the request edge;
  - the pipeline accepts one read per cycle; back-to-back reads give back-to-back rvalid.
- Data entering the first pipeline stage on a write cycle, by RW_MODE:
  - 0: old word;
  - 1: merged new word;
  - 2: stage 1 holds its previous value.
  - In all modes the stage valid bit is 0 for writes.
- When no request is issued, stage-1 data holds and stage-1 valid is 0.
- Out-of-range addresses (addr >= DEPTH): writes are ignored; reads return 0 with rvalid=1.
- A read of an address written on the previous edge returns the new data. No hazard logic is needed, since the array is registered.
- oe affects only the rdata gate, never rvalid or the pipeline contents.

Decomposition:
- Package sp_ram_pkg holds:
  - RW_READ_FIRST=0, RW_WRITE_FIRST=1, RW_NO_CHANGE=2;
  - the state encoding ST_INIT/ST_IDLE;
  - a function giving the byte-lane count, DATA_WIDTH/BYTE_WIDTH.
- Sub-module sp_ram_rd_pipe: a RD_LATENCY-deep data+valid shift pipeline with asynchronous reset to 0.
- The top level keeps the array, byte merge, clear FSM and RW_MODE select.

Test Plan:
1. Clear: defaults, memory pre-filled with 0xFFFF, rst_n released → busy=1 for exactly 16 cycles, then reads of addr 0..15 all return 0x0000 with rvalid.
2. Streaming: RD_LATENCY=2; write 16 words from $random to addr 0..15; issue 16 consecutive reads → rvalid high for 16 contiguous cycles, starting 2 edges after the first read; data matches in order.
3. Byte enable: write 0xABCD with be=2'b11 to addr 3, then 0x1234 with be=2'b01 to addr 3, then read addr 3 → 0xAB34; a write with be=2'b00 leaves 0xAB34.
4. RW_MODE: addr 5=0x1111, last rdata=0x7777, write 0x2222 to addr 5 → after the edge rdata is 0x1111 (mode 0), 0x2222 (mode 1), or 0x7777 (mode 2); rvalid=0 in every mode.
5. Reset mid-clear: assert rst_n low at INIT cycle 5 → rdata=0 and busy=1 immediately; after release, busy=1 for 16 more cycles; a cs=1 write issued during busy leaves no trace in memory.
6. Range and oe: DEPTH=12; write 0x5A5A to addr 13 → ignored; read addr 13 → rdata=0 with rvalid=1; read a valid address with oe=0 → rdata=0 and rvalid=1.
